// File: rtl/jump_ctl.sv
// -----------------------------------------------------------------------------
// jump_ctl
//   Gameplay controller between the keyboard decoder / block generator and the
//   character sprite block. A left/right key press is compared with the side
//   of the next platform block. The controller then issues a single-cycle
//   jump_left, jump_right or jump_fail command and waits for the character
//   block's landed pulse. A good landing advances the block generator and
//   scores a point. A fall, or a missing landed pulse, ends the game.
//
// Ports
//   clk          system clock (40 MHz)
//   rst          synchronous reset, active-high
//   module_en    0 holds the block in its reset state, exactly like rst
//   key_left     single-cycle left key press pulse
//   key_right    single-cycle right key press pulse
//   block_valid  block_side is valid
//   block_side   side of the next block: 0 = left, 1 = right
//   landed       single-cycle landing pulse from the character block
//   jump_left    single-cycle command: correct jump to the left
//   jump_right   single-cycle command: correct jump to the right
//   jump_fail    single-cycle command: wrong key, the character falls
//   block_next   single-cycle pulse: the block generator advances
//   score        number of successful landings, saturating at SCORE_MAX
//   game_over    level, held until rst or module_en low
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module jump_ctl #(
  parameter logic [23:0] LANDED_TIMEOUT = 24'd16_000_000,
  parameter logic [9:0]  SCORE_MAX      = 10'd999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       module_en,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       block_valid,
  input  logic       block_side,
  input  logic       landed,
  output logic       jump_left,
  output logic       jump_right,
  output logic       jump_fail,
  output logic       block_next,
  output logic [9:0] score,
  output logic       game_over
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_JUMP,
    S_FALL,
    S_OVER
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic        buf_valid_q, buf_valid_d;
  logic        buf_dir_q, buf_dir_d;
  logic        jump_left_q, jump_left_d;
  logic        jump_right_q, jump_right_d;
  logic        jump_fail_q, jump_fail_d;
  logic        block_next_q, block_next_d;
  logic [9:0]  score_q, score_d;
  logic        game_over_q, game_over_d;

  // A simultaneous left+right press is ambiguous, so it is dropped.
  logic key_fresh;
  logic timeout;

  assign key_fresh = key_left ^ key_right;
  assign timeout   = (timer_q == LANDED_TIMEOUT - 24'd1);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case statement, so no
    // path leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    timer_d      = timer_q;
    buf_valid_d  = buf_valid_q;
    buf_dir_d    = buf_dir_q;
    jump_left_d  = 1'b0;
    jump_right_d = 1'b0;
    jump_fail_d  = 1'b0;
    block_next_d = 1'b0;
    score_d      = score_q;
    game_over_d  = game_over_q;

    // The one-deep key buffer: the newest press overwrites whatever is
    // waiting. Once the game is over, key presses are dropped.
    if (key_fresh && (state_q != S_OVER)) begin
      buf_valid_d = 1'b1;
      buf_dir_d   = key_right;
    end

    case (state_q)
      S_IDLE: begin
        // Use the buffer after this cycle's update. A key arriving in this
        // cycle is therefore issued on the next cycle, with no extra delay.
        if (buf_valid_d && block_valid) begin
          if (buf_dir_d == block_side) begin
            jump_left_d  = ~buf_dir_d;
            jump_right_d =  buf_dir_d;
            state_d      = S_JUMP;
          end else begin
            jump_fail_d  = 1'b1;
            state_d      = S_FALL;
          end
          buf_valid_d = 1'b0;
          timer_d     = '0;
        end
      end

      S_JUMP: begin
        timer_d = timer_q + 24'd1;
        // If landed and the timeout happen in the same cycle, landed wins.
        if (landed) begin
          block_next_d = 1'b1;
          score_d      = (score_q >= SCORE_MAX) ? SCORE_MAX : score_q + 10'd1;
          state_d      = S_IDLE;
        end else if (timeout) begin
          game_over_d = 1'b1;
          state_d     = S_OVER;
        end
      end

      S_FALL: begin
        timer_d = timer_q + 24'd1;
        if (landed || timeout) begin
          game_over_d = 1'b1;
          state_d     = S_OVER;
        end
      end

      S_OVER: begin
        game_over_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. module_en low behaves exactly like rst.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples values from before the edge, whatever order
    // the statements are written in.
    if (rst || !module_en) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      buf_valid_q  <= 1'b0;
      buf_dir_q    <= 1'b0;
      jump_left_q  <= 1'b0;
      jump_right_q <= 1'b0;
      jump_fail_q  <= 1'b0;
      block_next_q <= 1'b0;
      score_q      <= '0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      buf_valid_q  <= buf_valid_d;
      buf_dir_q    <= buf_dir_d;
      jump_left_q  <= jump_left_d;
      jump_right_q <= jump_right_d;
      jump_fail_q  <= jump_fail_d;
      block_next_q <= block_next_d;
      score_q      <= score_d;
      game_over_q  <= game_over_d;
    end
  end

  assign jump_left  = jump_left_q;
  assign jump_right = jump_right_q;
  assign jump_fail  = jump_fail_q;
  assign block_next = block_next_q;
  assign score      = score_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_jump_ctl.sv
// -----------------------------------------------------------------------------
// tb_jump_ctl
//   Directed testbench for jump_ctl. LANDED_TIMEOUT is set to 100 so the
//   timeout path can be reached in a short run.
//
//   Inputs are driven 1 time unit after a rising edge and take effect at the
//   next edge. Outputs are sampled at that same point, 1 unit after an edge.
//   "cycle N" in a comment means the clock period in which the inputs are
//   driven.
// -----------------------------------------------------------------------------
module tb_jump_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       module_en;
  logic       key_left;
  logic       key_right;
  logic       block_valid;
  logic       block_side;
  logic       landed;
  logic       jump_left;
  logic       jump_right;
  logic       jump_fail;
  logic       block_next;
  logic [9:0] score;
  logic       game_over;

  int n_vec = 0;
  int n_err = 0;

  jump_ctl #(
    .LANDED_TIMEOUT(24'd100),
    .SCORE_MAX     (10'd999)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .module_en  (module_en),
    .key_left   (key_left),
    .key_right  (key_right),
    .block_valid(block_valid),
    .block_side (block_side),
    .landed     (landed),
    .jump_left  (jump_left),
    .jump_right (jump_right),
    .jump_fail  (jump_fail),
    .block_next (block_next),
    .score      (score),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  // Advance one cycle. Afterwards, the outputs show the result of the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Packs all outputs as {jl, jr, jf, bn, go, score}.
  function automatic logic [31:0] outs();
    return {17'd0, jump_left, jump_right, jump_fail, block_next, game_over, score};
  endfunction

  function automatic logic [31:0] pack(input logic jl, jr, jf, bn, go,
                                       input logic [9:0] sc);
    return {17'd0, jl, jr, jf, bn, go, sc};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Hard stop in case the run never reaches the summary line.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; module_en = 1'b1; key_left = 1'b0; key_right = 1'b0;
    block_valid = 1'b0; block_side = 1'b0; landed = 1'b0;
    #1;
    do_reset();
    check("reset_outputs", outs(), pack(0, 0, 0, 0, 0, 10'd0));

    // ---- Correct jump: key_right with the block on the right ----
    block_valid = 1'b1; block_side = 1'b1;
    key_right = 1'b1; tick(); key_right = 1'b0;
    check("correct_jump_right", outs(), pack(0, 1, 0, 0, 0, 10'd0));
    tick();
    check("jump_right_one_cycle", outs(), pack(0, 0, 0, 0, 0, 10'd0));
    tick(5);
    landed = 1'b1; tick(); landed = 1'b0;
    check("landing_block_next", outs(), pack(0, 0, 0, 1, 0, 10'd1));
    tick();
    check("block_next_one_cycle", outs(), pack(0, 0, 0, 0, 0, 10'd1));

    // ---- Buffering during a jump: the last press wins ----
    key_right = 1'b1; tick(); key_right = 1'b0;
    check("second_jump_right", outs(), pack(0, 1, 0, 0, 0, 10'd1));
    key_left  = 1'b1; tick(); key_left  = 1'b0;
    key_right = 1'b1; tick(); key_right = 1'b0;
    landed = 1'b1; tick(); landed = 1'b0;          // landed in cycle N
    check("buffered_landing_n1", outs(), pack(0, 0, 0, 1, 0, 10'd2));
    tick();                                        // cycle N+2
    check("buffered_issue_n2", outs(), pack(0, 1, 0, 0, 0, 10'd2));
    tick();
    check("buffered_issue_once", outs(), pack(0, 0, 0, 0, 0, 10'd2));

    // ---- Both keys in the same cycle: nothing is buffered ----
    key_left = 1'b1; key_right = 1'b1; tick(); key_left = 1'b0; key_right = 1'b0;
    landed = 1'b1; tick(); landed = 1'b0;
    check("both_keys_landing", outs(), pack(0, 0, 0, 1, 0, 10'd3));
    tick(2);
    check("both_keys_ignored", outs(), pack(0, 0, 0, 0, 0, 10'd3));

    // ---- block_valid gating ----
    block_valid = 1'b0; block_side = 1'b0;
    key_left = 1'b1; tick(); key_left = 1'b0;
    check("gated_no_command", outs(), pack(0, 0, 0, 0, 0, 10'd3));
    tick(3);
    check("gated_still_held", outs(), pack(0, 0, 0, 0, 0, 10'd3));
    block_valid = 1'b1; tick();
    check("gated_release_left", outs(), pack(1, 0, 0, 0, 0, 10'd3));
    landed = 1'b1; tick(); landed = 1'b0;
    check("left_landing", outs(), pack(0, 0, 0, 1, 0, 10'd4));

    // ---- landed in S_IDLE is ignored ----
    landed = 1'b1; tick(); landed = 1'b0;
    check("idle_landed_ignored", outs(), pack(0, 0, 0, 0, 0, 10'd4));

    // ---- Timeout: game_over exactly 100 cycles after entering S_JUMP ----
    block_side = 1'b1;
    key_right = 1'b1; tick(); key_right = 1'b0;     // cycle M: S_JUMP, timer 0
    check("timeout_jump_issued", outs(), pack(0, 1, 0, 0, 0, 10'd4));
    tick(99);
    check("timeout_m99_not_yet", outs(), pack(0, 0, 0, 0, 0, 10'd4));
    tick();
    check("timeout_m100_over", outs(), pack(0, 0, 0, 0, 1, 10'd4));
    key_right = 1'b1; tick(); key_right = 1'b0;
    check("over_key_ignored", outs(), pack(0, 0, 0, 0, 1, 10'd4));
    landed = 1'b1; tick(); landed = 1'b0;
    tick(2);
    check("over_frozen", outs(), pack(0, 0, 0, 0, 1, 10'd4));

    // ---- landed coinciding with the timeout: landed wins ----
    do_reset();
    key_right = 1'b1; tick(); key_right = 1'b0;     // cycle M
    tick(99);                                      // now driving cycle M+99
    landed = 1'b1; tick(); landed = 1'b0;
    check("landed_beats_timeout", outs(), pack(0, 0, 0, 1, 0, 10'd1));
    tick(2);
    check("landed_beats_timeout_idle", outs(), pack(0, 0, 0, 0, 0, 10'd1));

    // ---- Wrong key: the character falls ----
    block_side = 1'b0;
    key_right = 1'b1; tick(); key_right = 1'b0;
    check("wrong_key_fail", outs(), pack(0, 0, 1, 0, 0, 10'd1));
    tick();
    check("fail_one_cycle", outs(), pack(0, 0, 0, 0, 0, 10'd1));
    landed = 1'b1; tick(); landed = 1'b0;
    check("fall_landed_over", outs(), pack(0, 0, 0, 0, 1, 10'd1));
    key_left = 1'b1; tick(); key_left = 1'b0;
    check("fall_over_no_cmd", outs(), pack(0, 0, 0, 0, 1, 10'd1));

    // ---- module_en low clears game over ----
    module_en = 1'b0; tick(); module_en = 1'b1;
    check("module_en_clears", outs(), pack(0, 0, 0, 0, 0, 10'd0));

    // ---- Score saturation ----
    do_reset();
    block_side = 1'b1;
    for (int i = 0; i < 999; i++) begin
      key_right = 1'b1; tick(); key_right = 1'b0;
      landed = 1'b1; tick(); landed = 1'b0;
    end
    check("score_preload_999", outs(), pack(0, 0, 0, 1, 0, 10'd999));
    key_right = 1'b1; tick(); key_right = 1'b0;
    landed = 1'b1; tick(); landed = 1'b0;
    check("score_saturates", outs(), pack(0, 0, 0, 1, 0, 10'd999));

    // ---- rst mid-jump ----
    key_right = 1'b1; tick(); key_right = 1'b0;
    check("pre_rst_jump", outs(), pack(0, 1, 0, 0, 0, 10'd999));
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_jump", outs(), pack(0, 0, 0, 0, 0, 10'd0));
    landed = 1'b1; tick(); landed = 1'b0;
    check("rst_back_to_idle", outs(), pack(0, 0, 0, 0, 0, 10'd0));

    // ---- module_en low mid-jump ----
    key_right = 1'b1; tick(); key_right = 1'b0;
    check("pre_en_jump", outs(), pack(0, 1, 0, 0, 0, 10'd0));
    module_en = 1'b0; landed = 1'b1; tick(); landed = 1'b0; module_en = 1'b1;
    check("en_low_mid_jump", outs(), pack(0, 0, 0, 0, 0, 10'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
